// File: rtl/memory_stage.sv
// memory_stage: pipeline MEM stage.
// Issues load/store accesses on a req/ack data bus, stalls upstream while an
// access is outstanding, formats load data and registers REG_MEM_WB.
// Optional alignment trap: define MEM_MISALIGN_CHECK_EN to turn misaligned
// accesses into a non-writing, bus-free fault pulse instead of a bus request.

package memory_stage_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] aluOut;
        logic [63:0] rs2;
        logic        isWriteBack;
        logic [4:0]  wd;
        logic        isMemRead;
        logic        isMemWrite;
        logic [2:0]  memMode;     // [1:0] size (B/H/W/D), [2] zero-extend load
        logic [63:0] instrAddr;
        logic [31:0] instr;
    } REG_EX_MEM;

    typedef struct packed {
        logic        valid;
        logic        isWriteBack;
        logic [4:0]  wd;
        logic [63:0] wdData;
        logic [63:0] instrAddr;
        logic [31:0] instr;
    } REG_MEM_WB;

    typedef struct packed {
        logic        valid;
        logic        isWb;
        logic [4:0]  wd;
        logic [63:0] wdData;
    } FORWARD_SOURCE;

endpackage

module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  REG_EX_MEM         moduleIn,
    output REG_MEM_WB         moduleOut,
    output FORWARD_SOURCE     forwardSource,
    output logic              memStall,
    output logic              dreqValid,
    output logic              dreqWrite,
    output logic [ADDR_W-1:0] dreqAddr,
    output logic [1:0]        dreqSize,
    output logic [7:0]        dreqStrobe,
    output logic [63:0]       dreqData,
    input  logic              drespDataOk,
    input  logic [63:0]       drespData,
    output logic              memFault
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e    state_q, state_d;
    REG_MEM_WB out_q, out_d;
    logic      fault_q, fault_d;

    logic        memop;
    logic        is_store;
    logic        misaligned;
    logic [2:0]  off;
    logic [1:0]  size;
    logic [5:0]  shamt;
    logic [7:0]  size_mask;
    logic [63:0] line_shifted;
    logic [63:0] load_data;
    logic        sext;
    REG_MEM_WB   pass;

    assign memop    = moduleIn.valid & (moduleIn.isMemRead | moduleIn.isMemWrite);
    // Both read and write set is illegal; the write wins.
    assign is_store = moduleIn.isMemWrite;
    assign off      = moduleIn.aluOut[2:0];
    assign size     = moduleIn.memMode[1:0];
    assign shamt    = {off, 3'b000};
    assign sext     = ~moduleIn.memMode[2];

    // Byte-enable template for the access size, before lane alignment.
    always_comb begin
        case (size)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

`ifdef MEM_MISALIGN_CHECK_EN
    // Address bits that must be zero for the access size (H: 1, W: 2, D: 3 bits).
    logic [2:0] align_mask;
    assign align_mask = {size_mask[4], size_mask[2], size_mask[1]};
    assign misaligned = memop & (|(off & align_mask));
`else
    // No check: misaligned accesses go to the bus with the raw address.
    assign misaligned = 1'b0;
`endif

    // Request fields come straight from the upstream register, which the
    // stall holds stable for the whole access.
    assign dreqValid  = (state_q == BUSY);
    assign dreqWrite  = is_store;
    assign dreqAddr   = moduleIn.aluOut[ADDR_W-1:0];
    assign dreqSize   = size;
    assign dreqStrobe = size_mask << off;
    assign dreqData   = moduleIn.rs2 << shamt;

    // Load alignment: bring the addressed byte down to lane 0.
    assign line_shifted = drespData >> shamt;

    // Truncate the aligned load to its size and sign- or zero-extend it.
    always_comb begin
        case (size)
            2'd0:    load_data = {{56{sext & line_shifted[7]}},  line_shifted[7:0]};
            2'd1:    load_data = {{48{sext & line_shifted[15]}}, line_shifted[15:0]};
            2'd2:    load_data = {{32{sext & line_shifted[31]}}, line_shifted[31:0]};
            default: load_data = line_shifted;
        endcase
    end

    // Writeback record for a straight pass-through of the incoming instruction.
    always_comb begin
        pass.valid       = moduleIn.valid;
        pass.isWriteBack = moduleIn.isWriteBack;
        pass.wd          = moduleIn.wd;
        pass.wdData      = moduleIn.aluOut;
        pass.instrAddr   = moduleIn.instrAddr;
        pass.instr       = moduleIn.instr;
    end

    // Next state, stall and next writeback record.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        out_d       = out_q;
        out_d.valid = 1'b0;
        fault_d     = 1'b0;
        memStall    = 1'b0;
        case (state_q)
            IDLE: begin
                if (misaligned) begin
                    out_d             = pass;
                    out_d.valid       = 1'b1;
                    out_d.isWriteBack = 1'b0;
                    fault_d           = 1'b1;
                end else if (memop) begin
                    memStall = 1'b1;
                    state_d  = BUSY;
                end else begin
                    out_d = pass;
                end
            end
            BUSY: begin
                if (drespDataOk) begin
                    state_d     = IDLE;
                    out_d       = pass;
                    out_d.valid = 1'b1;
                    if (!is_store) begin
                        out_d.wdData = load_data;
                    end
                end else begin
                    memStall = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bypass info: load data is only visible on the completing cycle.
    always_comb begin
        forwardSource.valid  = moduleIn.valid;
        forwardSource.isWb   = moduleIn.isWriteBack;
        forwardSource.wd     = moduleIn.wd;
        forwardSource.wdData = moduleIn.aluOut;
        if ((state_q == BUSY) && drespDataOk && !is_store) begin
            forwardSource.wdData = load_data;
        end
    end

    // State, writeback register and fault pulse; reset drops any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            out_q   <= out_d;
            fault_q <= fault_d;
        end
    end

    assign moduleOut = out_q;
    assign memFault  = fault_q;

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline MEM stage. Consumes the REG_EX_MEM register written by the execute stage and issues load/store transactions on the data bus with a req/ack handshake.
- Formats load data and registers REG_MEM_WB for writeback.
- Drives a stall back to all upstream stage registers while a bus access is outstanding.
- Publishes a FORWARD_SOURCE for the decode stage's bypass network.

Parameters:
- ADDR_W, 64, data-bus address width; the low ADDR_W bits of aluOut are used.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- moduleIn  input  REG_EX_MEM  uses valid, aluOut, rs2, isWriteBack, wd, isMemRead, isMemWrite, memMode, instrAddr, instr
- moduleOut  output  REG_MEM_WB  valid, isWriteBack, wd, wdData, instrAddr, instr
- forwardSource  output  FORWARD_SOURCE  bypass info for decode
- memStall  output  1  combinational; high holds all upstream stage registers
- dreqValid  output  1  data-bus request valid
- dreqWrite  output  1  1=store, 0=load
- dreqAddr  output  ADDR_W  access address (aluOut)
- dreqSize  output  2  0=B, 1=H, 2=W, 3=D
- dreqStrobe  output  8  byte enables, stores only
- dreqData  output  64  lane-aligned store data
- drespDataOk  input  1  one-cycle pulse: access complete
- drespData  input  64  raw 64-bit aligned line for loads
- memFault  output  1  misalignment pulse (feature only, else tied 0)

Behaviour:
- memMode encoding: [1:0] size (same code as dreqSize); [2] = 1 means zero-extend load.
- memop = moduleIn.valid & (isMemRead | isMemWrite).
- FSM states:
  - IDLE: memop → memStall=1, next state BUSY. Non-memop → no stall; moduleOut <= moduleIn fields with wdData=aluOut, latency 1 cycle.
  - BUSY: dreqValid=1. All dreq* signals are held stable and derived from the held moduleIn.
    - memStall = ~drespDataOk.
    - On the drespDataOk cycle, the edge writes moduleOut with valid=1 and wdData = formatted load data (stores: aluOut), then returns to IDLE. Upstream advances on the same edge.
- While memStall=1, moduleOut.valid <= 0 each edge so writeback never double-commits.
- Store formatting:
  - off = aluOut[2:0].
  - dreqData = rs2 << (8*off).
  - dreqStrobe = sizemask << off, where sizemask is 0x01, 0x03, 0x0F or 0xFF by size.
- Load formatting:
  - raw = drespData >> (8*off), truncated to the access size.
  - Sign-extended when memMode[2]=0, zero-extended when memMode[2]=1, to 64 bits.
- forwardSource:
  - valid = moduleIn.valid; isWb = moduleIn.isWriteBack; wd = moduleIn.wd.
  - wdData = formatted load data when in BUSY with drespDataOk, else aluOut.
  - Consumers sample it only when memStall=0.
- Reset (any time, including mid-BUSY): state=IDLE, dreqValid=0, moduleOut.valid=0, memFault=0, all other moduleOut fields 0.
- A drespDataOk arriving in IDLE (stale response after reset) is ignored.
- moduleIn.valid=0: no request, moduleOut.valid <= 0, memStall=0.
- Both isMemRead and isMemWrite set is illegal; store takes precedence.

Optional Feature:
- MEM_MISALIGN_CHECK_EN defined:
  - An access with aluOut not aligned to its size (H: bit0; W: bits[1:0]; D: bits[2:0]) issues no bus request and causes no stall.
  - moduleOut written next edge with valid=1 and isWriteBack=0.
  - memFault pulses 1 for that cycle (registered).
- Undefined: no check. The request is issued with the raw address; the byte shift spills off the top of the lane and correctness is the bus's responsibility. memFault is constant 0.

Test Plan:
- ALU op (valid, no mem, aluOut=0x1234, wd=5) → next cycle moduleOut.valid=1, wdData=0x1234, memStall never high.
- LB addr 0x1003, drespData=0x00000000_80000000, drespDataOk 3 cycles after request → memStall high 4 cycles; wdData=0xFFFFFFFFFFFFFF80; zero-extend mode gives 0x80.
- SH addr 0x2006, rs2=0xABCD → dreqStrobe=0xC0, dreqData=0xABCD000000000000, dreqWrite=1; moduleOut.isWriteBack passthrough 0.
- Back-to-back LD then ADD → ADD held until the LD's drespDataOk; the LD's moduleOut is followed by the ADD's moduleOut the next cycle; no duplicate valid.
- rst asserted in BUSY → dreqValid=0 immediately; a subsequent stray drespDataOk produces no moduleOut.valid.
- With MEM_MISALIGN_CHECK_EN: LW addr 0x1002 → dreqValid stays 0, memFault=1 for one cycle, moduleOut.isWriteBack=0.
